// File: rtl/board_referee.sv
// Tic-tac-toe referee: validates player moves, keeps the 3x3 board and
// reports win/draw with the completed lines after a one-cycle evaluation.
module board_referee (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       move_P1_i,
    input  logic [3:0] move_P1,
    input  logic       move_P2_i,
    input  logic [3:0] move_P2,
    output logic       illegal_move,
    output logic       over,
    output logic [1:0] winner,
    output logic [7:0] win_line,
    output logic [8:0] board_p1,
    output logic [8:0] board_p2,
    output logic       turn,
    output logic [3:0] move_count
);

    typedef enum logic [1:0] {PLAY, EVAL, DONE} state_t;

    state_t     state, state_next;
    logic       illegal_next, over_next, turn_next;
    logic [1:0] winner_next;
    logic [7:0] win_line_next;
    logic [8:0] board_p1_next, board_p2_next;
    logic [3:0] count_next;

    logic       any_strobe, both_strobe, mover, legal;
    logic [3:0] pos;
    logic [8:0] mask;
    logic [7:0] hits;

    // Position p lives at bit 9-p, so position 1 is the MSB.
    function automatic logic [7:0] line_hits(input logic [8:0] b);
        logic [7:0] h;
        h[0] = b[8] & b[7] & b[6];
        h[1] = b[5] & b[4] & b[3];
        h[2] = b[2] & b[1] & b[0];
        h[3] = b[8] & b[5] & b[2];
        h[4] = b[7] & b[4] & b[1];
        h[5] = b[6] & b[3] & b[0];
        h[6] = b[8] & b[4] & b[0];
        h[7] = b[6] & b[4] & b[2];
        return h;
    endfunction

    // Out-of-range positions are screened separately; the mask is only used when 1..9.
    function automatic logic [8:0] pos_mask(input logic [3:0] p);
        return 9'h100 >> (p - 4'd1);
    endfunction

    always_comb begin
        any_strobe  = move_P1_i | move_P2_i;
        both_strobe = move_P1_i & move_P2_i;
        mover       = move_P2_i;
        pos         = move_P2_i ? move_P2 : move_P1;
        mask        = pos_mask(pos);
        legal       = !both_strobe && (mover == turn) && (pos >= 4'd1) && (pos <= 4'd9)
                      && (((board_p1 | board_p2) & mask) == 9'd0);
        hits        = line_hits(turn ? board_p2 : board_p1);
    end

    always_comb begin
        state_next    = state;
        illegal_next  = 1'b0;
        over_next     = over;
        turn_next     = turn;
        winner_next   = winner;
        win_line_next = win_line;
        board_p1_next = board_p1;
        board_p2_next = board_p2;
        count_next    = move_count;

        if (new_game) begin
            state_next    = PLAY;
            over_next     = 1'b0;
            turn_next     = 1'b0;
            winner_next   = 2'b00;
            win_line_next = 8'd0;
            board_p1_next = 9'd0;
            board_p2_next = 9'd0;
            count_next    = 4'd0;
        end else begin
            case (state)
                PLAY: begin
                    if (any_strobe) begin
                        if (legal) begin
                            if (mover) board_p2_next = board_p2 | mask;
                            else       board_p1_next = board_p1 | mask;
                            count_next = move_count + 4'd1;
                            state_next = EVAL;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                EVAL: begin
                    illegal_next = any_strobe;
                    if (hits != 8'd0) begin
                        winner_next   = turn ? 2'b10 : 2'b01;
                        win_line_next = hits;
                        over_next     = 1'b1;
                        state_next    = DONE;
                    end else if (move_count == 4'd9) begin
                        winner_next   = 2'b11;
                        win_line_next = 8'd0;
                        over_next     = 1'b1;
                        state_next    = DONE;
                    end else begin
                        turn_next  = ~turn;
                        state_next = PLAY;
                    end
                end
                DONE: ;
                default: state_next = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PLAY;
            illegal_move <= 1'b0;
            over         <= 1'b0;
            turn         <= 1'b0;
            winner       <= 2'b00;
            win_line     <= 8'd0;
            board_p1     <= 9'd0;
            board_p2     <= 9'd0;
            move_count   <= 4'd0;
        end else begin
            state        <= state_next;
            illegal_move <= illegal_next;
            over         <= over_next;
            turn         <= turn_next;
            winner       <= winner_next;
            win_line     <= win_line_next;
            board_p1     <= board_p1_next;
            board_p2     <= board_p2_next;
            move_count   <= count_next;
        end
    end

endmodule
